// File: rtl/fp_pkg.sv
// Shared types and constants for the fixed-point multiply/accumulate datapath.
package fp_pkg;

  typedef enum logic [1:0] {
    MUL = 2'b00,
    MAC = 2'b01,
    LDA = 2'b10,
    NOP = 2'b11
  } op_t;

  localparam int RND_TRUNC     = 0;
  localparam int RND_HALF_UP   = 1;
  localparam int RND_HALF_EVEN = 2;

endpackage

// File: rtl/fp_round_sat.sv
// Combinational round-and-saturate: drops F fraction bits from an IN_W-bit
// signed value and clamps the rounded result into N signed bits.
module fp_round_sat
  import fp_pkg::*;
#(
  parameter int IN_W = 20,
  parameter int N    = 8,
  parameter int F    = 7,
  parameter int RND  = RND_HALF_UP
) (
  input  logic signed [IN_W-1:0] v_i,
  output logic signed [N-1:0]    res_o,
  output logic                   sat_o
);

  // One spare MSB so the rounding increment can never wrap.
  localparam int QW = IN_W - F + 1;
  localparam logic [F-1:0]         HALF = F'(1) << (F - 1);
  localparam logic signed [QW-1:0] MAXV = QW'((1 << (N - 1)) - 1);
  localparam logic signed [QW-1:0] MINV = ~MAXV;

  logic signed [QW-1:0] q;
  logic signed [QW-1:0] r;
  logic [F-1:0]         frac;
  logic                 inc;

  assign q    = {v_i[IN_W-1], v_i[IN_W-1:F]};
  assign frac = v_i[F-1:0];

  always_comb begin
    inc = 1'b0;
    case (RND)
      RND_HALF_UP:   inc = frac[F-1];
      RND_HALF_EVEN: inc = (frac > HALF) || ((frac == HALF) && q[0]);
      default:       inc = 1'b0;
    endcase
    r     = q + QW'(inc);
    res_o = r[N-1:0];
    sat_o = 1'b0;
    if (r > MAXV) begin
      res_o = MAXV[N-1:0];
      sat_o = 1'b1;
    end else if (r < MINV) begin
      res_o = MINV[N-1:0];
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/fp_mac_unit.sv
// Pipelined signed fixed-point MUL/MAC unit: S1 multiplies, S2 selects the
// value and owns the accumulator, the output rank rounds and saturates.
module fp_mac_unit
  import fp_pkg::*;
#(
  parameter int N   = 8,
  parameter int F   = 7,
  parameter int G   = 4,
  parameter int RND = RND_HALF_UP
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  input  logic [1:0]          op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] result,
  output logic                sat
);

  localparam int PW     = 2 * N;
  localparam int ACC_W  = 2 * N + G;
  localparam int STAGES = 3;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [STAGES:1]         vld_pipe_q;
  logic                    advance;
  logic signed [PW-1:0]    p_q;
  op_t                     op1_q;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] v_q, v_d;
  logic                    nop2_q;
  logic signed [ACC_W-1:0] p_ext;
  logic signed [ACC_W:0]   sum;
  logic signed [N-1:0]     rs_res, result_q;
  logic                    rs_sat, sat_q;

  // The whole pipe moves in lockstep; it only stalls when the output is held.
  assign advance   = !vld_pipe_q[STAGES] || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_pipe_q[STAGES];
  assign result    = result_q;
  assign sat       = sat_q;

  assign p_ext = ACC_W'(p_q);
  assign sum   = (ACC_W+1)'(acc_q) + (ACC_W+1)'(p_ext);

  always_comb begin
    v_d   = p_ext;
    acc_d = acc_q;
    case (op1_q)
      MAC: begin
        if (sum[ACC_W] != sum[ACC_W-1]) v_d = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        else                            v_d = sum[ACC_W-1:0];
        acc_d = v_d;
      end
      LDA:     acc_d = p_ext;
      default: acc_d = acc_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_pipe_q <= '0;
      p_q        <= '0;
      op1_q      <= NOP;
      acc_q      <= '0;
      v_q        <= '0;
      nop2_q     <= 1'b0;
      result_q   <= '0;
      sat_q      <= 1'b0;
    end else if (advance) begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], in_valid};
      if (in_valid) begin
        p_q   <= PW'(a) * PW'(b);
        op1_q <= op_t'(op);
      end
      // Bubbles skip this branch, so they never disturb the accumulator.
      if (vld_pipe_q[1]) begin
        acc_q  <= acc_d;
        v_q    <= v_d;
        nop2_q <= (op1_q == NOP);
      end
      if (vld_pipe_q[2]) begin
        result_q <= nop2_q ? '0 : rs_res;
        sat_q    <= !nop2_q && rs_sat;
      end
    end
  end

  fp_round_sat #(
    .IN_W (ACC_W),
    .N    (N),
    .F    (F),
    .RND  (RND)
  ) u_round_sat (
    .v_i   (v_q),
    .res_o (rs_res),
    .sat_o (rs_sat)
  );

endmodule
